// File: rtl/rr_arbiter3_pkg.sv
// Shared constants, state encoding and the modulo-3 pointer helper for the
// three-way round-robin arbiter.
package rr_arbiter3_pkg;

    localparam int ID_W = 2;
    localparam logic [2:0] NO_GRANT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    // (base + step) mod 3; inputs may be up to 3 so two folds may be needed.
    function automatic logic [ID_W-1:0] rr_wrap(input logic [ID_W-1:0] base,
                                                input logic [ID_W-1:0] step);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd6) begin
            sum = sum - 3'd6;
        end else if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[ID_W-1:0];
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first eligible requester after 'last',
// wrapping modulo 3. 'mask' removes requesters from consideration.
module rr_pick3
    import rr_arbiter3_pkg::*;
(
    input  logic [2:0]      req,
    input  logic [ID_W-1:0] last,
    input  logic [2:0]      mask,
    output logic            any,
    output logic [ID_W-1:0] winner,
    output logic [2:0]      onehot
);

    logic [2:0]      elig;
    logic [2:0]      cand_hit;
    logic [ID_W-1:0] cand_id [3];

    assign elig = req & mask;
    assign any  = |elig;

    // cand_id[0] is highest priority: the master right after the last owner.
    for (genvar gi = 0; gi < 3; gi++) begin : g_order
        assign cand_id[gi]  = rr_wrap(last, ID_W'(gi + 1));
        assign cand_hit[gi] = elig[cand_id[gi]];
    end

    always_comb begin
        winner = cand_id[2];
        if (cand_hit[0]) begin
            winner = cand_id[0];
        end else if (cand_hit[1]) begin
            winner = cand_id[1];
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_decode
        assign onehot[gi] = any & (winner == ID_W'(gi));
    end

endmodule

// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter with registered one-hot grant and an
// optional hold-time limit that revokes long tenures.
module rr_arbiter3
    import rr_arbiter3_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req,
    output logic [2:0]      gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout
);

    state_t          state_reg;
    logic [2:0]      gnt_reg;
    logic [ID_W-1:0] gnt_id_reg;
    logic            busy_reg;
    logic            timeout_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ID_W-1:0] last_reg;

    logic            pick_any;
    logic [ID_W-1:0] pick_winner;
    logic [2:0]      pick_onehot;
    logic [2:0]      pick_mask;
    logic            owner_req;
    logic            hold_hit;

    // While granted, last_reg equals the owner, and the owner is excluded so
    // the same picker serves release handoff and timeout revocation alike.
    assign pick_mask = (state_reg == ST_GRANT) ? ~gnt_reg : 3'b111;
    assign owner_req = |(req & gnt_reg);
    assign hold_hit  = (MAX_HOLD != 0) && (cnt_reg == CNT_W'(MAX_HOLD));

    rr_pick3 u_pick (
        .req    (req),
        .last   (last_reg),
        .mask   (pick_mask),
        .any    (pick_any),
        .winner (pick_winner),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= NO_GRANT;
            gnt_id_reg  <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
            last_reg    <= ID_W'(2);
        end else begin
            timeout_reg <= 1'b0;
            if (state_reg == ST_GRANT && owner_req && !hold_hit) begin
                if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                // A release that coincides with the hold limit stays a release.
                if (state_reg == ST_GRANT && owner_req) begin
                    timeout_reg <= 1'b1;
                end
                if (pick_any) begin
                    state_reg  <= ST_GRANT;
                    gnt_reg    <= pick_onehot;
                    gnt_id_reg <= pick_winner;
                    busy_reg   <= 1'b1;
                    cnt_reg    <= CNT_W'(1);
                    last_reg   <= pick_winner;
                end else begin
                    state_reg  <= (state_reg == ST_GRANT && owner_req) ? ST_BACKOFF : ST_IDLE;
                    gnt_reg    <= NO_GRANT;
                    gnt_id_reg <= '0;
                    busy_reg   <= 1'b0;
                    cnt_reg    <= '0;
                end
            end
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Directed bench for rr_arbiter3 with MAX_HOLD=4: a behavioural model pushes
// expected outputs per driven request, checked after the following clock edge.
module tb_rr_arbiter3;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter3 #(.MAX_HOLD(MH), .CNT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb[$];

    int m_state;
    int m_owner;
    int m_cnt;
    int m_last;

    logic [2:0] t2_req [10] = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b111,
                                3'b111, 3'b101, 3'b111, 3'b111, 3'b011};
    logic [2:0] t2_gnt [10] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                                3'b010, 3'b100, 3'b100, 3'b100, 3'b001};
    logic [2:0] t4_gnt [12] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b100,
                                3'b100, 3'b100, 3'b100, 3'b000, 3'b100, 3'b100};
    logic       t4_to  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int last, input int excl);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = 2;
        sb.delete();
    endtask

    task automatic take(input int w);
        m_state = 1;
        m_owner = w;
        m_last  = w;
        m_cnt   = 1;
    endtask

    task automatic model_step(input logic [2:0] r);
        int   w;
        exp_t e;
        logic to;
        to = 1'b0;
        if (m_state == 1) begin
            if (r[m_owner] && m_cnt == MH) begin
                to = 1'b1;
                w = pick(r, m_last, m_owner);
                if (w >= 0) take(w);
                else begin m_state = 2; m_cnt = 0; end
            end else if (r[m_owner]) begin
                if (m_cnt < 31) m_cnt++;
            end else begin
                w = pick(r, m_last, m_owner);
                if (w >= 0) take(w);
                else begin m_state = 0; m_cnt = 0; end
            end
        end else begin
            w = pick(r, m_last, -1);
            if (w >= 0) take(w);
            else begin m_state = 0; m_cnt = 0; end
        end
        e.gnt  = (m_state == 1) ? 3'(1 << m_owner) : 3'b000;
        e.id   = (m_state == 1) ? 2'(m_owner) : 2'd0;
        e.busy = (m_state == 1);
        e.to   = to;
        sb.push_back(e);
    endtask

    task automatic step(input logic [2:0] r, input string tag);
        exp_t e;
        @(negedge clk);
        req = r;
        model_step(r);
        @(posedge clk);
        #1;
        $display("%s req=%b gnt=%b id=%0d busy=%b timeout=%b", tag, r, gnt, gnt_id, busy, timeout);
        chk({tag, ".sb_nonempty"}, 8'(sb.size() != 0), 8'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".gnt"},     8'(gnt),     8'(e.gnt));
            chk({tag, ".gnt_id"},  8'(gnt_id),  8'(e.id));
            chk({tag, ".busy"},    8'(busy),    8'(e.busy));
            chk({tag, ".timeout"}, 8'(timeout), 8'(e.to));
        end
        chk({tag, ".busy_or"}, 8'(busy), 8'(|gnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt",     8'(gnt),     8'h0);
        chk("rst.gnt_id",  8'(gnt_id),  8'h0);
        chk("rst.busy",    8'(busy),    8'h0);
        chk("rst.timeout", 8'(timeout), 8'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single requester: one-cycle latency, release on drop.
        step(3'b001, "t1.req");
        chk("t1.gnt_dir", 8'(gnt), 8'h1);
        step(3'b001, "t1.hold");
        step(3'b001, "t1.hold");
        step(3'b000, "t1.rel");
        chk("t1.rel_dir", 8'(gnt), 8'h0);

        // All request, owners release after three cycles: order 0,1,2,0.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(t2_req[i], "t2.rr");
            chk("t2.order", 8'(gnt), 8'(t2_gnt[i]));
        end

        // Timeout hands off to the other requester in the same cycle.
        do_reset();
        repeat (4) step(3'b011, "t3.hold");
        chk("t3.pre_gnt", 8'(gnt), 8'h1);
        step(3'b011, "t3.revoke");
        chk("t3.timeout", 8'(timeout), 8'h1);
        chk("t3.handoff", 8'(gnt), 8'h2);
        step(3'b011, "t3.after");
        chk("t3.pulse_end", 8'(timeout), 8'h0);
        step(3'b000, "t3.idle");

        // Lone requester: periodic backoff cycle with timeout pulse.
        for (int i = 0; i < 12; i++) begin
            step(3'b100, "t4.solo");
            chk("t4.gnt", 8'(gnt), 8'(t4_gnt[i]));
            chk("t4.to",  8'(timeout), 8'(t4_to[i]));
        end
        step(3'b000, "t4.idle");

        // Release in the same cycle the hold limit is reached.
        repeat (4) step(3'b011, "t5.hold");
        step(3'b010, "t5.rel_at_max");
        chk("t5.no_timeout", 8'(timeout), 8'h0);
        chk("t5.handoff", 8'(gnt), 8'h2);

        // Asynchronous reset mid-tenure, then pointer restarts at master 0.
        #2;
        reset = 1'b1;
        req   = 3'b000;
        #1;
        chk("t6.async_gnt",  8'(gnt),    8'h0);
        chk("t6.async_busy", 8'(busy),   8'h0);
        chk("t6.async_id",   8'(gnt_id), 8'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(3'b110, "t6.restart");
        chk("t6.gnt_dir", 8'(gnt), 8'h2);
        chk("t6.id_dir",  8'(gnt_id), 8'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter3.md
Name: rr_arbiter3

Overview:
- Three-requester round-robin arbiter with a bounded hold time.
- Shares one single-ported resource, such as a scratchpad or I/O port behind a KCPSM3 core, between three masters.
- The grant decode is one AND-of-three term per requester; this block adds the sequencing and fairness around that decode.
- Sits between the requesting masters and the resource's select/mux lines.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure; 0 = unlimited (no timeout).
- CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- req  input  3  request per master; held high for the whole tenure.
- gnt  output  3  one-hot grant, registered; 000 = resource free.
- gnt_id  output  2  index of granted master; 0 when gnt=000.
- busy  output  1  OR of gnt, registered.
- timeout  output  1  one-cycle pulse when a tenure is revoked by MAX_HOLD.

Behaviour:
- Reset (async, active-high):
  - gnt=000, gnt_id=0, busy=0, timeout=0.
  - Hold counter = 0; state = IDLE.
  - last-owner pointer = 2, so master 0 has first priority.
- Round-robin pick:
  - Search order starts at (last+1) mod 3 and wraps: e.g. last=1 gives order 2,0,1.
  - The owner pointer updates on every new grant.
- IDLE:
  - If req != 000 in cycle N, gnt = one-hot(winner) in cycle N+1; go to GRANT.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT:
  - The hold counter increments every cycle gnt is asserted; it is 1 in the first grant cycle.
  - Release: if req[owner]=0 sampled in cycle N, then in N+1 gnt = next winner among the remaining req bits, or 000 and IDLE if none.
  - There are no dead cycles on handoff; the counter reloads to 1 for the new owner.
  - A requester that drops req for one cycle and re-raises it competes as a new request.
- Timeout (MAX_HOLD>0):
  - Condition: counter == MAX_HOLD and req[owner]=1 in cycle N.
  - In N+1: timeout=1, gnt = next winner excluding the revoked owner.
  - If no other requester is pending, gnt=000 for N+1 (state BACKOFF), then normal arbitration from N+2; the revoked owner may be regranted in N+2.
  - timeout is high for exactly one cycle.
- MAX_HOLD=0: counter saturates at its maximum and is ignored; no timeout ever occurs.
- Simultaneous release and timeout (req[owner]=0 in the same cycle the counter hits MAX_HOLD): treated as a release; no timeout pulse.
- Requests that change mid-tenure from non-owners have no effect until the owner releases or is revoked.
- Reset mid-tenure: all outputs drop asynchronously; after reset deassert, arbitration restarts from the reset pointer (master 0 first).
- Invariants:
  - gnt is always 000 or one-hot.
  - gnt_id matches gnt.
  - busy = |gnt.
  - gnt is never asserted to a master whose req was low in the previous cycle.
- States: IDLE, GRANT, BACKOFF; 2-bit encoding.

Decomposition:
- Shared package holds:
  - state constants ST_IDLE=0, ST_GRANT=1, ST_BACKOFF=2;
  - the ID-width constant (2);
  - the NO_GRANT=3'b000 constant.
- One combinational sub-module, rr_pick3:
  - Inputs: req[2:0], last[1:0], mask[2:0].
  - Outputs: any, winner[1:0], onehot[2:0].
  - It is used for both normal and excluding-owner picks.
- All registers live in rr_arbiter3.

Test Plan:
- Reset, then req=001 at cycle 2 -> gnt=001, gnt_id=0, busy=1 at cycle 3; req drops at 5 -> gnt=000 at 6.
- After reset, req=111 held and each owner releases after 3 cycles -> grant order 0,1,2,0 with back-to-back handoff and no gnt=000 cycles.
- MAX_HOLD=4, req=011 held, owner 0 granted -> after 4 grant cycles timeout=1 for one cycle and gnt=010 in the same cycle.
- MAX_HOLD=4, only req=100 held -> 4 cycles gnt=100, then one cycle gnt=000 with timeout=1, then gnt=100 again; repeats periodically.
- Owner drops req in the same cycle its counter reaches MAX_HOLD -> next cycle timeout=0 and handoff follows the release rule.
- Assert reset while gnt=010 mid-tenure -> gnt=000, busy=0 immediately (async); after release with req=110, gnt=010 (pointer reset to 2, search 0,1,2).
